// File: rtl/frame_config_sequencer.sv
// frame_config_sequencer: turns a 32-bit configuration word stream into frame
// writes. Hunts for the sync word, decodes frame-write headers, gathers one
// word per fabric row onto FrameData and pulses the addressed FrameStrobe bit.
// Optional feature macro: FRAME_CHECKSUM_EN appends an XOR checksum word to
// every frame; a mismatch flags err and suppresses the strobe.
module frame_config_sequencer #(
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned NUM_ROWS        = 4,
    parameter int unsigned NUM_COLS        = 4,
    parameter logic [31:0] SYNC_WORD       = 32'hFAB0_FAB1,
    parameter int unsigned STROBE_CYCLES   = 1     // legal range 1..15
) (
    input  logic                                  CLK,
    input  logic                                  resetn,
    input  logic [31:0]                           s_data,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    output logic [NUM_ROWS*FrameBitsPerRow-1:0]   FrameData,
    output logic [NUM_COLS*MaxFramesPerCol-1:0]   FrameStrobe,
    output logic                                  synced,
    output logic                                  busy,
    output logic                                  err,
    output logic [15:0]                           frame_count
);

    typedef enum logic [1:0] {
        S_HUNT,
        S_HEADER,
        S_DATA,
        S_STROBE
    } state_t;

    localparam int unsigned ROW_W = $clog2(NUM_ROWS + 1);
`ifdef FRAME_CHECKSUM_EN
    localparam int unsigned WORDS = NUM_ROWS + 1;
`else
    localparam int unsigned WORDS = NUM_ROWS;
`endif
    localparam logic [ROW_W-1:0] LAST_WORD = ROW_W'(WORDS - 1);
    localparam logic [ROW_W-1:0] ROW_LIM   = ROW_W'(NUM_ROWS);
    localparam logic [3:0]       LAST_SCNT = 4'(STROBE_CYCLES - 1);
    localparam logic [7:0]       COL_LIM   = 8'(NUM_COLS);
    localparam logic [7:0]       FRM_LIM   = 8'(MaxFramesPerCol);

    state_t                                r_state;
    state_t                                w_next_state;
    logic                                  r_ready;
    logic                                  r_synced;
    logic                                  r_busy;
    logic                                  r_err;
    logic [15:0]                           r_fcnt;
    logic [NUM_ROWS*FrameBitsPerRow-1:0]   r_fd;
    logic [NUM_COLS*MaxFramesPerCol-1:0]   r_strobe;
    logic [NUM_COLS*MaxFramesPerCol-1:0]   w_onehot;
    logic [7:0]                            r_col;
    logic [7:0]                            r_frm;
    logic [ROW_W-1:0]                      r_row;
    logic [3:0]                            r_scnt;

    logic w_accept;
    logic w_hdr_ok;
    logic w_last_word;
    logic w_sum_ok;
    logic w_load_hdr;
    logic w_wr_word;
    logic w_set_err;
    logic w_clr_err;
    logic w_start_strobe;
    logic w_end_strobe;

    assign w_accept    = s_valid && r_ready;
    assign w_hdr_ok    = (r_col < COL_LIM) && (r_frm < FRM_LIM);
    assign w_last_word = (r_row == LAST_WORD);

`ifdef FRAME_CHECKSUM_EN
    logic [31:0] r_xor;
    assign w_sum_ok = (s_data == r_xor);
`else
    assign w_sum_ok = 1'b1;
`endif

    // State register
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        w_next_state   = r_state;
        w_load_hdr     = 1'b0;
        w_wr_word      = 1'b0;
        w_set_err      = 1'b0;
        w_clr_err      = 1'b0;
        w_start_strobe = 1'b0;
        w_end_strobe   = 1'b0;
        case (r_state)
            S_HUNT: begin
                if (w_accept && (s_data == SYNC_WORD)) begin
                    w_next_state = S_HEADER;
                    w_clr_err    = 1'b1;
                end
            end
            S_HEADER: begin
                if (w_accept) begin
                    if (s_data[31:28] == 4'hA) begin
                        w_next_state = S_DATA;
                        w_load_hdr   = 1'b1;
                    end else if (s_data[31:28] == 4'hD) begin
                        w_next_state = S_HUNT;
                    end else begin
                        w_set_err = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_wr_word = 1'b1;
                    if (w_last_word) begin
                        if (w_hdr_ok && w_sum_ok) begin
                            w_next_state   = S_STROBE;
                            w_start_strobe = 1'b1;
                        end else begin
                            w_next_state = S_HEADER;
                            w_set_err    = 1'b1;
                        end
                    end
                end
            end
            S_STROBE: begin
                if (r_scnt == LAST_SCNT) begin
                    w_next_state = S_HEADER;
                    w_end_strobe = 1'b1;
                end
            end
            default: w_next_state = S_HUNT;
        endcase
    end

    // One-hot strobe pattern for the latched column/frame address
    always_comb begin
        w_onehot = '0;
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
            for (int unsigned f = 0; f < MaxFramesPerCol; f++) begin
                if ((r_col == 8'(c)) && (r_frm == 8'(f))) begin
                    w_onehot[c*MaxFramesPerCol + f] = 1'b1;
                end
            end
        end
    end

    // Registered status outputs, strobe pulse and frame counter
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_ready  <= 1'b0;
            r_synced <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_fcnt   <= '0;
            r_strobe <= '0;
            r_scnt   <= '0;
        end else begin
            r_ready  <= (w_next_state != S_STROBE);
            r_synced <= (w_next_state != S_HUNT);
            r_busy   <= (w_next_state == S_DATA) || (w_next_state == S_STROBE);
            if (w_clr_err) begin
                r_err <= 1'b0;
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end
            if (w_start_strobe) begin
                r_strobe <= w_onehot;
                r_scnt   <= '0;
            end else if (w_end_strobe) begin
                r_strobe <= '0;
                r_fcnt   <= r_fcnt + 16'd1;
            end else if (r_state == S_STROBE) begin
                r_scnt <= r_scnt + 4'd1;
            end
        end
    end

    // Header latch, row counter and row data capture
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_col <= '0;
            r_frm <= '0;
            r_row <= '0;
            r_fd  <= '0;
`ifdef FRAME_CHECKSUM_EN
            r_xor <= '0;
`endif
        end else begin
            if (w_load_hdr) begin
                r_col <= s_data[15:8];
                r_frm <= s_data[7:0];
                r_row <= '0;
`ifdef FRAME_CHECKSUM_EN
                r_xor <= '0;
`endif
            end else if (w_wr_word) begin
                r_row <= r_row + ROW_W'(1);
`ifdef FRAME_CHECKSUM_EN
                if (r_row < ROW_LIM) begin
                    r_xor <= r_xor ^ s_data;
                end
`endif
            end
            // The checksum word (index NUM_ROWS) matches no row and is not stored.
            for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                if (w_wr_word && (r_row == ROW_W'(r))) begin
                    r_fd[r*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
                end
            end
        end
    end

    assign s_ready     = r_ready;
    assign synced      = r_synced;
    assign busy        = r_busy;
    assign err         = r_err;
    assign frame_count = r_fcnt;
    assign FrameData   = r_fd;
    assign FrameStrobe = r_strobe;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Bench for frame_config_sequencer: two instances (STROBE_CYCLES 1 and 3),
// a frame-level vector table, hand sequences for stall / held-valid / reset
// during strobe, and a strobe scoreboard. Honours FRAME_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_frame_config_sequencer;
    localparam int unsigned NR = 4;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic        CLK = 1'b0;
    logic        resetn [2];
    logic [31:0] s_data [2];
    logic        s_valid[2];
    logic        s_ready[2];
    logic [127:0] fdata [2];
    logic [79:0]  fstb  [2];
    logic        synced [2];
    logic        busy   [2];
    logic        err    [2];
    logic [15:0] fcnt   [2];

    frame_config_sequencer #(.STROBE_CYCLES(1)) u_dut1 (
        .CLK(CLK), .resetn(resetn[0]), .s_data(s_data[0]), .s_valid(s_valid[0]),
        .s_ready(s_ready[0]), .FrameData(fdata[0]), .FrameStrobe(fstb[0]),
        .synced(synced[0]), .busy(busy[0]), .err(err[0]), .frame_count(fcnt[0]));

    frame_config_sequencer #(.STROBE_CYCLES(3)) u_dut3 (
        .CLK(CLK), .resetn(resetn[1]), .s_data(s_data[1]), .s_valid(s_valid[1]),
        .s_ready(s_ready[1]), .FrameData(fdata[1]), .FrameStrobe(fstb[1]),
        .synced(synced[1]), .busy(busy[1]), .err(err[1]), .frame_count(fcnt[1]));

    always #5 CLK = ~CLK;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        int unsigned  inst;
        int unsigned  bitn;
        logic [127:0] fd;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [31:0] hdr;
        bit          with_data;
        bit          exp_ok;
        int unsigned bitn;
        bit          exp_err;
    } vec_t;
    vec_t vecs[11];

    logic [127:0] exp_fd [2];
    int unsigned  exp_cnt[2];

    function automatic int unsigned plen(input int unsigned i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the word is accepted.
    task automatic send_word(input int unsigned i, input logic [31:0] w);
        int unsigned t;
        t = 0;
        s_data[i]  = w;
        s_valid[i] = 1'b1;
        while (s_ready[i] !== 1'b1 && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 50) begin
            n_vec++;
            n_miss++;
            $display("FAIL ready_timeout dut%0d: s_ready=%b expected 1", i, s_ready[i]);
        end
        @(negedge CLK);
        s_valid[i] = 1'b0;
    endtask

    task automatic send_frame(input int unsigned i, input logic [31:0] hdr, input logic [127:0] rows,
                              input bit exp_ok, input int unsigned bitn, input int unsigned stall_at);
        logic [31:0] cs;
        exp_t e;
        cs = '0;
        send_word(i, hdr);
        if (exp_ok) begin
            e.inst = i; e.bitn = bitn; e.fd = rows;
            sbq.push_back(e);
        end
        for (int unsigned k = 0; k < NR; k++) begin
            send_word(i, rows[k*32 +: 32]);
            cs ^= rows[k*32 +: 32];
            if (k == stall_at) begin
                repeat (5) begin
                    chk("stall_busy", busy[i], 1);
                    chk("stall_no_strobe", fstb[i], 0);
                    @(negedge CLK);
                end
            end
        end
`ifdef FRAME_CHECKSUM_EN
        send_word(i, cs);
`endif
        exp_fd[i] = rows;
        if (exp_ok) begin
            exp_cnt[i]++;
            chk("strobe_start", fstb[i][bitn], 1);
        end else begin
            chk("no_strobe", fstb[i], 0);
        end
    endtask

    // Strobe monitor: pops the scoreboard at each pulse start, checks width.
    bit           in_pulse[2];
    int unsigned  plen_c  [2];
    logic [127:0] cur_fd  [2];
    always @(negedge CLK) begin : mon
        exp_t        e;
        logic [79:0] one;
        for (int unsigned i = 0; i < 2; i++) begin
            if (!resetn[i]) begin
                in_pulse[i] = 0;
                plen_c[i]   = 0;
            end else if (fstb[i] != '0) begin
                if (!in_pulse[i]) begin
                    in_pulse[i] = 1;
                    plen_c[i]   = 0;
                    if (sbq.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        cur_fd[i] = fdata[i];
                        $display("FAIL unexpected_strobe dut%0d: got %0h expected none", i, fstb[i]);
                    end else begin
                        e = sbq.pop_front();
                        one = '0;
                        one[e.bitn] = 1'b1;
                        cur_fd[i] = e.fd;
                        chk("sb_inst", i, e.inst);
                        chk("sb_strobe", fstb[i], one);
                    end
                end
                plen_c[i]++;
                chk("strobe_onehot", $countones(fstb[i]), 1);
                chk("strobe_ready_low", s_ready[i], 0);
                chk("strobe_fd_stable", fdata[i], cur_fd[i]);
            end else if (in_pulse[i]) begin
                in_pulse[i] = 0;
                chk("strobe_len", plen_c[i], plen(i));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rows;
        vecs[0]  = '{32'hA000_0203, 1'b1, 1'b1, 43, 1'b0};
        vecs[1]  = '{32'hA000_0500, 1'b1, 1'b0,  0, 1'b1};
        vecs[2]  = '{32'hA000_0014, 1'b1, 1'b0,  0, 1'b1};
        vecs[3]  = '{32'hA000_0400, 1'b1, 1'b0,  0, 1'b1};
        vecs[4]  = '{32'hA000_0313, 1'b1, 1'b1, 79, 1'b0};
        vecs[5]  = '{32'hA000_0000, 1'b1, 1'b1,  0, 1'b0};
        vecs[6]  = '{32'hA0FF_0105, 1'b1, 1'b1, 25, 1'b0};
        vecs[7]  = '{32'h1234_5678, 1'b0, 1'b0,  0, 1'b1};
        vecs[8]  = '{32'hFAB0_FAB1, 1'b0, 1'b0,  0, 1'b1};
        vecs[9]  = '{32'hA000_FF13, 1'b1, 1'b0,  0, 1'b1};
        vecs[10] = '{32'hA000_0113, 1'b1, 1'b1, 39, 1'b0};

        for (int unsigned i = 0; i < 2; i++) begin
            resetn[i] = 1'b0; s_valid[i] = 1'b0; s_data[i] = '0;
            exp_fd[i] = '0; exp_cnt[i] = 0;
        end
        repeat (3) @(negedge CLK);
        for (int unsigned i = 0; i < 2; i++) begin
            chk("rst_fdata", fdata[i], 0);
            chk("rst_strobe", fstb[i], 0);
            chk("rst_ready", s_ready[i], 0);
            chk("rst_synced", synced[i], 0);
            chk("rst_busy", busy[i], 0);
            chk("rst_err", err[i], 0);
            chk("rst_fcnt", fcnt[i], 0);
        end
        resetn[0] = 1'b1; resetn[1] = 1'b1;
        #1;
        chk("ready_first_cycle", s_ready[0], 0);
        @(negedge CLK);
        chk("ready_after_first", s_ready[0], 1);

        // Words before sync are discarded
        send_word(0, 32'hDEAD_BEEF);
        send_word(0, 32'hA000_0000);
        send_word(0, 32'h1111_1111);
        chk("presync_synced", synced[0], 0);
        chk("presync_busy", busy[0], 0);
        chk("presync_strobe", fstb[0], 0);
        send_word(0, SYNC);
        chk("sync_synced", synced[0], 1);
        chk("sync_busy", busy[0], 0);

        // Reference frame: column 2, frame 3
        send_frame(0, 32'hA000_0203, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 1, 43, NR);
        chk("ref_busy_in_strobe", busy[0], 1);
        @(negedge CLK);
        chk("ref_strobe_done", fstb[0], 0);
        chk("ref_ready", s_ready[0], 1);
        chk("ref_busy", busy[0], 0);
        chk("ref_fcnt", fcnt[0], 1);
        chk("ref_err", err[0], 0);
        chk("ref_fdata", fdata[0], 128'h44444444_33333333_22222222_11111111);

        // Table of headers, each preceded by desync + resync to clear err
        for (int unsigned v = 0; v < 11; v++) begin
            send_word(0, 32'hD000_0000);
            chk("desync_synced", synced[0], 0);
            chk("desync_busy", busy[0], 0);
            send_word(0, SYNC);
            chk("resync_err_clear", err[0], 0);
            chk("resync_synced", synced[0], 1);
            if (vecs[v].with_data) begin
                rows = {$urandom, $urandom, $urandom, $urandom};
                send_frame(0, vecs[v].hdr, rows, vecs[v].exp_ok, vecs[v].bitn, NR);
            end else begin
                send_word(0, vecs[v].hdr);
                chk("hdr_no_strobe", fstb[0], 0);
            end
            repeat (2) @(negedge CLK);
            chk("vec_err", err[0], vecs[v].exp_err);
            chk("vec_busy", busy[0], 0);
            chk("vec_synced", synced[0], 1);
            chk("vec_fcnt", fcnt[0], exp_cnt[0]);
            chk("vec_fdata", fdata[0], exp_fd[0]);
            chk("vec_strobe_idle", fstb[0], 0);
        end

        // s_valid low mid-frame stalls without losing progress
        send_word(0, 32'hD000_0000);
        send_word(0, SYNC);
        rows = {$urandom, $urandom, $urandom, $urandom};
        send_frame(0, 32'hA000_0101, rows, 1, 21, 1);
        repeat (2) @(negedge CLK);
        chk("stall_fcnt", fcnt[0], exp_cnt[0]);
        chk("stall_fdata", fdata[0], exp_fd[0]);

`ifdef FRAME_CHECKSUM_EN
        begin
            exp_t e;
            send_word(0, 32'hD000_0000);
            send_word(0, SYNC);
            send_word(0, 32'hA000_0000);
            e.inst = 0; e.bitn = 0; e.fd = 128'h8_00000004_00000002_00000001;
            sbq.push_back(e);
            send_word(0, 32'h1); send_word(0, 32'h2); send_word(0, 32'h4); send_word(0, 32'h8);
            send_word(0, 32'hF);
            exp_cnt[0]++;
            chk("cs_good_strobe", fstb[0][0], 1);
            repeat (2) @(negedge CLK);
            chk("cs_good_err", err[0], 0);
            chk("cs_good_fcnt", fcnt[0], exp_cnt[0]);
            send_word(0, 32'hA000_0000);
            send_word(0, 32'h1); send_word(0, 32'h2); send_word(0, 32'h4); send_word(0, 32'h8);
            send_word(0, 32'hE);
            chk("cs_bad_no_strobe", fstb[0], 0);
            repeat (2) @(negedge CLK);
            chk("cs_bad_err", err[0], 1);
            chk("cs_bad_busy", busy[0], 0);
            chk("cs_bad_fcnt", fcnt[0], exp_cnt[0]);
            chk("cs_bad_fdata", fdata[0], 128'h8_00000004_00000002_00000001);
        end
`endif

        // Three-cycle strobe with the next header held valid
        send_word(1, SYNC);
        rows = {$urandom, $urandom, $urandom, $urandom};
        send_frame(1, 32'hA000_0013, rows, 1, 19, NR);
        s_data[1]  = 32'hA000_0202;
        s_valid[1] = 1'b1;
        for (int unsigned c = 0; c < 3; c++) begin
            chk("long_strobe_bit", fstb[1][19], 1);
            chk("long_strobe_ready", s_ready[1], 0);
            @(negedge CLK);
        end
        chk("long_after_strobe", fstb[1], 0);
        chk("long_after_ready", s_ready[1], 1);
        chk("long_after_busy", busy[1], 0);
        chk("long_after_fcnt", fcnt[1], 1);
        @(negedge CLK);
        s_valid[1] = 1'b0;
        chk("long_next_hdr_taken", busy[1], 1);

        // Finish that frame, then pull reset during its strobe
        begin
            exp_t e;
            logic [31:0] cs;
            cs = '0;
            rows = {$urandom, $urandom, $urandom, $urandom};
            e.inst = 1; e.bitn = 42; e.fd = rows;
            sbq.push_back(e);
            for (int unsigned k = 0; k < NR; k++) begin
                send_word(1, rows[k*32 +: 32]);
                cs ^= rows[k*32 +: 32];
            end
`ifdef FRAME_CHECKSUM_EN
            send_word(1, cs);
`endif
        end
        chk("rst_mid_strobe_pre", fstb[1][42], 1);
        #2;
        resetn[1] = 1'b0;
        #1;
        chk("rst_mid_strobe", fstb[1], 0);
        chk("rst_mid_fcnt", fcnt[1], 0);
        chk("rst_mid_busy", busy[1], 0);
        chk("rst_mid_synced", synced[1], 0);
        chk("rst_mid_ready", s_ready[1], 0);
        chk("rst_mid_fdata", fdata[1], 0);
        repeat (2) @(negedge CLK);
        resetn[1] = 1'b1;
        @(negedge CLK);
        send_word(1, SYNC);
        chk("rst_recover_synced", synced[1], 1);

        repeat (3) @(negedge CLK);
        chk("sb_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/frame_config_sequencer.md
Name: frame_config_sequencer

Overview:
- Sequences fabric configuration loading: accepts a 32-bit word stream, detects the sync word, decodes frame-write headers, assembles one frame of row data and pulses the matching FrameStrobe bit.
- Sits between the bitstream source (UART/bit-bang/SPI front end) and the per-tile frame latches. Drives the global FrameData/FrameStrobe buses.

Parameters:
- FrameBitsPerRow, 32, data bits per row per frame; fixed at 32 for this block.
- MaxFramesPerCol, 20, frames per column; width of each column's strobe slice.
- NUM_ROWS, 4, fabric rows; number of data words per frame.
- NUM_COLS, 4, fabric columns.
- SYNC_WORD, 32'hFAB0_FAB1, stream sync pattern.
- STROBE_CYCLES, 1, strobe high time in cycles; legal range 1..15.

Ports:
- CLK  in  1  clock.
- resetn  in  1  async active-low reset.
- s_data  in  32  stream word.
- s_valid  in  1  word valid.
- s_ready  out  1  word accepted when s_valid&&s_ready.
- FrameData  out  NUM_ROWS*32  row r at [r*32 +: 32].
- FrameStrobe  out  NUM_COLS*MaxFramesPerCol  column c, frame f at bit c*MaxFramesPerCol+f.
- synced  out  1  sync word seen, desync not yet received.
- busy  out  1  state != HUNT and state != HEADER.
- err  out  1  sticky error flag.
- frame_count  out  16  frames strobed since reset; wraps at 16'hFFFF->0.

Behaviour:
- Reset (async, resetn=0): state HUNT; FrameData=0, FrameStrobe=0, s_ready=0, synced=0, busy=0, err=0, frame_count=0; row/strobe counters=0. Reset mid-strobe drops the strobe immediately.
- s_ready=1 in HUNT, HEADER, DATA; 0 in STROBE and for the first cycle after reset release. All outputs registered.
- HUNT: consume words; word==SYNC_WORD -> HEADER, synced=1, err cleared to 0. Others discarded.
- HEADER: opcode=s_data[31:28].
  - 4'hA frame write: latch col=s_data[15:8], frm=s_data[7:0], row_idx=0 -> DATA.
  - 4'hD desync -> HUNT, synced=0.
  - Any other opcode: err=1, word dropped, stay HEADER.
  - A SYNC_WORD in HEADER is treated as an opcode (0xF): error.
- DATA: accepted word k written to FrameData row k; the other rows are unchanged. After word NUM_ROWS-1 -> STROBE if the header is valid (col<NUM_COLS and frm<MaxFramesPerCol). Otherwise err=1 and -> HEADER without strobing; the words are still consumed.
- STROBE: the selected FrameStrobe bit is high for exactly STROBE_CYCLES consecutive cycles starting the cycle after the last data word is accepted. All other bits stay 0. FrameData is stable throughout. On the last strobe cycle, frame_count increments. The next cycle, strobe is 0, state is HEADER and s_ready=1.
- At most one FrameStrobe bit is high at any time.
- FrameData holds its last value until overwritten.
- s_valid low in any state: stall, no state change.

Optional Feature:
- Macro FRAME_CHECKSUM_EN.
- Defined:
  - DATA expects NUM_ROWS+1 words. The last word is the checksum: XOR of the NUM_ROWS data words.
  - Match plus valid header -> STROBE.
  - Mismatch -> err=1, no strobe, -> HEADER. FrameData keeps the loaded rows.
- Undefined: no checksum word; behaviour as above.

Test Plan:
- Reset, then stream SYNC, 0xA000_0203, 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> FrameData={0x44444444,0x33333333,0x22222222,0x11111111}; FrameStrobe bit 2*20+3=43 high 1 cycle, 1 cycle after the last word; frame_count=1; err=0.
- Words before SYNC (0xDEADBEEF, 0xA0000000) -> ignored, synced=0, no strobe; then SYNC -> synced=1.
- Header 0xA000_0500 (col 5 ≥ 4) plus 4 data words -> no strobe, err=1, back in HEADER. Then SYNC, desync 0xD0000000, SYNC -> err=0.
- STROBE_CYCLES=3, valid frame col 0 frm 19, s_valid held high -> bit 19 high 3 cycles, s_ready=0 those 3 cycles, next header accepted the cycle after.
- resetn pulled low during STROBE -> FrameStrobe=0 same cycle, state HUNT, frame_count=0.
- FRAME_CHECKSUM_EN: data 1,2,4,8 with checksum 0xF -> strobe. The same data with checksum 0xE -> err=1, no strobe.
